// File: rtl/eth_fcs_filter.sv
// Store-and-forward Ethernet FCS checker: buffers each frame, checks its CRC-32,
// releases good frames on a ready/valid stream and discards bad/runt/overflowing ones.
module eth_fcs_filter #(
  parameter int DEPTH     = 2048,
  parameter int LEN_Q     = 8,
  parameter int MIN_LEN   = 64,
  parameter int STRIP_FCS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_good,
  output logic        frame_bad,
  output logic        frame_drop,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic [15:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int QW = $clog2(LEN_Q) + 1;
  // Residue C704DD7B expressed in the bit order of the right-shifting register.
  localparam logic [31:0] RESIDUE_REFL = 32'hDEBB20E3;
  localparam logic [PW-1:0] FCS_ADJ = PW'(STRIP_FCS != 0 ? 4 : 0);
  localparam logic [PW-1:0] RD_SKIP = PW'(STRIP_FCS != 0 ? 5 : 1);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, len, iss_cnt;
  logic [31:0]   crc, crc_nx;
  logic          ovf;
  logic [PW-1:0] lq [LEN_Q];
  logic [QW-1:0] lq_wr, lq_rd, iss_ptr;

  logic [PW-1:0] occ, head_len;
  logic full_now, wr_en, ovf_now, eof, lq_full, is_drop, is_bad, is_good;
  logic avail, load, iss_last, accept;

  assign occ      = wr_ptr - rd_ptr;
  assign full_now = (occ == PW'(DEPTH));
  assign wr_en    = in_valid && !ovf && !full_now;
  assign ovf_now  = ovf || (in_valid && full_now);
  assign crc_nx   = crc_byte(crc, in_data);
  assign eof      = in_valid && in_last;
  assign lq_full  = ((lq_wr - lq_rd) == QW'(LEN_Q));
  assign is_drop  = ovf_now || lq_full;
  assign is_bad   = !is_drop && (((len + PW'(1)) < PW'(MIN_LEN)) || (crc_nx != RESIDUE_REFL));
  assign is_good  = eof && !is_drop && !is_bad;

  // Issue side runs one frame ahead of the pop side so frames stream without bubbles.
  assign head_len = lq[iss_ptr[QW-2:0]];
  assign avail    = (iss_ptr != lq_wr);
  assign load     = avail && (!out_valid || out_ready);
  assign iss_last = (iss_cnt == head_len - PW'(1));
  assign accept   = out_valid && out_ready;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len        <= '0;
      crc        <= '1;
      ovf        <= 1'b0;
      lq_wr      <= '0;
      for (int k = 0; k < LEN_Q; k++) lq[k] <= '0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      frame_drop <= 1'b0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      frame_good <= is_good;
      frame_bad  <= eof && is_bad;
      frame_drop <= eof && is_drop;
      if (is_good && good_cnt != 16'hFFFF)         good_cnt <= good_cnt + 16'd1;
      if (eof && is_bad && bad_cnt != 16'hFFFF)    bad_cnt  <= bad_cnt + 16'd1;
      if (eof && is_drop && drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
      if (eof) begin
        crc <= '1;
        len <= '0;
        ovf <= 1'b0;
        if (is_good) begin
          wr_ptr                <= wr_ptr + PW'(1);
          commit_ptr            <= wr_ptr + PW'(1);
          lq[lq_wr[QW-2:0]]     <= len + PW'(1) - FCS_ADJ;
          lq_wr                 <= lq_wr + QW'(1);
        end else begin
          wr_ptr <= commit_ptr;
        end
      end else if (in_valid) begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + PW'(1);
          crc    <= crc_nx;
          len    <= len + PW'(1);
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      iss_cnt   <= '0;
      iss_ptr   <= '0;
      lq_rd     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= mem[rd_ptr[AW-1:0]];
        out_valid <= 1'b1;
        out_last  <= iss_last;
        if (iss_last) begin
          rd_ptr  <= rd_ptr + RD_SKIP;
          iss_cnt <= '0;
          iss_ptr <= iss_ptr + QW'(1);
        end else begin
          rd_ptr  <= rd_ptr + PW'(1);
          iss_cnt <= iss_cnt + PW'(1);
        end
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (accept && out_last) lq_rd <= lq_rd + QW'(1);
    end
  end
endmodule

// File: tb/tb_eth_fcs_filter.sv
// Bench for eth_fcs_filter: two configurations driven with random frames and
// checked against a frame-level reference model (table CRC, outcome rules, byte queues).
module tb_eth_fcs_filter;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0][7:0]  in_data, out_data;
  logic [1:0]       in_valid, in_last, out_ready, out_valid, out_last;
  logic [1:0]       frame_good, frame_bad, frame_drop;
  logic [1:0][15:0] good_cnt, bad_cnt, drop_cnt;

  int tests = 0, fails = 0;
  logic [31:0] crc_tab [256];
  logic [8:0]  exp_q [2][$];
  int          flen  [2][$];
  int stored[2], pend[2], e_good[2], e_bad[2], e_drop[2], p_good[2], p_bad[2], p_drop[2];
  logic [1:0]      prev_v, prev_r;
  logic [1:0][8:0] prev_d;

  always #5 clk = ~clk;

  eth_fcs_filter #(.DEPTH(64), .LEN_Q(2), .MIN_LEN(8), .STRIP_FCS(1)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]), .out_ready(out_ready[0]),
    .frame_good(frame_good[0]), .frame_bad(frame_bad[0]), .frame_drop(frame_drop[0]),
    .good_cnt(good_cnt[0]), .bad_cnt(bad_cnt[0]), .drop_cnt(drop_cnt[0]));

  eth_fcs_filter #(.DEPTH(256), .LEN_Q(4), .MIN_LEN(64), .STRIP_FCS(0)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]), .out_ready(out_ready[1]),
    .frame_good(frame_good[1]), .frame_bad(frame_bad[1]), .frame_drop(frame_drop[1]),
    .good_cnt(good_cnt[1]), .bad_cnt(bad_cnt[1]), .drop_cnt(drop_cnt[1]));

  function automatic int depth_of(int i);  return (i == 0) ? 64 : 256; endfunction
  function automatic int lenq_of(int i);   return (i == 0) ? 2 : 4;    endfunction
  function automatic int minlen_of(int i); return (i == 0) ? 8 : 64;   endfunction
  function automatic int strip_of(int i);  return (i == 0) ? 1 : 0;    endfunction

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Standard Ethernet CRC-32 (with final inversion), table driven.
  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) c = crc_tab[c[7:0] ^ b[k]] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic bq_t mk_frame(input int n, input bit good);
    bq_t b;
    logic [31:0] c;
    for (int k = 0; k < n; k++) b.push_back(8'($urandom));
    c = crc32(b, n);
    for (int k = 0; k < 4; k++) b.push_back(c[8*k +: 8]);
    if (!good) b[n+3] = b[n+3] ^ 8'h01;
    return b;
  endfunction

  task automatic predict(input int i, input bq_t f);
    int n, m;
    bit ok;
    n  = f.size();
    ok = (crc32(f, n - 4) == {f[n-1], f[n-2], f[n-3], f[n-4]});
    if (stored[i] + n > depth_of(i) || pend[i] == lenq_of(i)) e_drop[i]++;
    else if (n < minlen_of(i) || !ok) e_bad[i]++;
    else begin
      e_good[i]++;
      m = (strip_of(i) != 0) ? n - 4 : n;
      for (int k = 0; k < m; k++) exp_q[i].push_back({(k == m - 1), f[k]});
      stored[i] += n;
      pend[i]++;
      flen[i].push_back(n);
    end
  endtask

  task automatic send(input int i, input bq_t f, input bit keep);
    predict(i, f);
    for (int k = 0; k < f.size(); k++) begin
      in_valid[i] = 1'b1;
      in_data[i]  = f[k];
      in_last[i]  = (k == f.size() - 1);
      tick();
    end
    if (!keep) begin
      in_valid[i] = 1'b0;
      in_last[i]  = 1'b0;
    end
  endtask

  task automatic wait_drain(input int i);
    for (int k = 0; k < 3000 && exp_q[i].size() != 0; k++) tick();
    check("drain", i, 32'(exp_q[i].size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic chk_counts(input int i);
    check("good_cnt", i, 32'(good_cnt[i]), 32'(e_good[i]));
    check("bad_cnt",  i, 32'(bad_cnt[i]),  32'(e_bad[i]));
    check("drop_cnt", i, 32'(drop_cnt[i]), 32'(e_drop[i]));
    check("good_pulses", i, 32'(p_good[i]), 32'(e_good[i]));
    check("bad_pulses",  i, 32'(p_bad[i]),  32'(e_bad[i]));
    check("drop_pulses", i, 32'(p_drop[i]), 32'(e_drop[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      flen[i].delete();
      stored[i] = 0; pend[i] = 0; e_good[i] = 0; e_bad[i] = 0; e_drop[i] = 0;
    end
  endtask

  // Output scoreboard, stall stability and pulse counting.
  always @(negedge clk) begin
    logic [9:0] e;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        prev_v[i] = 1'b0; prev_r[i] = 1'b0;
        p_good[i] = 0; p_bad[i] = 0; p_drop[i] = 0;
      end else begin
        if (frame_good[i]) p_good[i]++;
        if (frame_bad[i])  p_bad[i]++;
        if (frame_drop[i]) p_drop[i]++;
        if (prev_v[i] && !prev_r[i]) begin
          check("stall_valid", i, 32'(out_valid[i]), 32'd1);
          check("stall_hold", i, 32'({out_last[i], out_data[i]}), 32'(prev_d[i]));
        end
        if (out_valid[i] && out_ready[i]) begin
          e = (exp_q[i].size() != 0) ? {1'b0, exp_q[i].pop_front()} : 10'h3FF;
          check("out_byte", i, 32'({1'b0, out_last[i], out_data[i]}), 32'(e));
          if (out_last[i] && flen[i].size() != 0) begin
            stored[i] -= flen[i].pop_front();
            pend[i]--;
          end
        end
        prev_v[i] = out_valid[i];
        prev_r[i] = out_ready[i];
        prev_d[i] = {out_last[i], out_data[i]};
      end
    end
  end

  initial begin
    bq_t f;
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
    in_data = '0; in_valid = '0; in_last = '0; out_ready = '0;
    model_reset();
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
      check("rst_out_last",  i, 32'(out_last[i]),  32'd0);
      check("rst_out_data",  i, 32'(out_data[i]),  32'd0);
      chk_counts(i);
    end
    rst = 1'b1;
    tick();

    // Known check frame "123456789" with its FCS.
    out_ready = 2'b11;
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    send(0, f, 1'b0);
    wait_drain(0);
    chk_counts(0);

    // Corrupted FCS followed back-to-back by a good frame.
    f[12] = 8'hCA;
    send(0, f, 1'b1);
    send(0, mk_frame(20, 1'b1), 1'b0);
    wait_drain(0);
    chk_counts(0);

    // Runt boundary (7 bad, 8 good) and a random bad FCS.
    send(0, mk_frame(3, 1'b1), 1'b0);
    send(0, mk_frame(4, 1'b1), 1'b0);
    send(0, mk_frame(30, 1'b0), 1'b0);
    wait_drain(0);
    chk_counts(0);

    // Config B: runts at 20 and 63 bytes, exact 64-byte minimum accepted.
    send(1, mk_frame(16, 1'b1), 1'b0);
    send(1, mk_frame(59, 1'b1), 1'b0);
    send(1, mk_frame(60, 1'b1), 1'b0);
    wait_drain(1);
    chk_counts(1);

    // 68 bytes forwarded with FCS under random backpressure.
    out_ready[1] = 1'b0;
    send(1, mk_frame(64, 1'b1), 1'b0);
    for (int k = 0; k < 3000 && exp_q[1].size() != 0; k++) begin
      out_ready[1] = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready[1] = 1'b1;
    wait_drain(1);
    chk_counts(1);

    // Buffer overflow on the second 40-byte frame, then a wrapping third frame.
    out_ready[0] = 1'b0;
    send(0, mk_frame(36, 1'b1), 1'b0);
    send(0, mk_frame(36, 1'b1), 1'b0);
    repeat (3) tick();
    chk_counts(0);
    out_ready[0] = 1'b1;
    wait_drain(0);
    send(0, mk_frame(36, 1'b1), 1'b0);
    wait_drain(0);
    chk_counts(0);

    // Two stored frames must stream with no idle cycle between them.
    out_ready[1] = 1'b0;
    send(1, mk_frame(64, 1'b1), 1'b0);
    send(1, mk_frame(64, 1'b1), 1'b0);
    repeat (4) tick();
    out_ready[1] = 1'b1;
    repeat (136) tick();
    check("no_bubble_left", 1, 32'(exp_q[1].size()), 32'd0);
    check("idle_after", 1, 32'(out_valid[1]), 32'd0);
    repeat (2) tick();
    chk_counts(1);

    // Length queue full on the third frame.
    out_ready[0] = 1'b0;
    send(0, mk_frame(6, 1'b1), 1'b0);
    send(0, mk_frame(6, 1'b1), 1'b0);
    send(0, mk_frame(6, 1'b1), 1'b0);
    repeat (3) tick();
    chk_counts(0);

    // Reset while A is mid-output and B is mid-frame.
    out_ready[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    in_valid = '0;
    in_last  = '0;
    model_reset();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst2_out_valid", i, 32'(out_valid[i]), 32'd0);
      check("rst2_out_last",  i, 32'(out_last[i]),  32'd0);
      chk_counts(i);
    end
    rst = 1'b1;
    tick();
    send(0, mk_frame(10, 1'b1), 1'b0);
    send(1, mk_frame(64, 1'b1), 1'b0);
    wait_drain(0);
    wait_drain(1);
    chk_counts(0);
    chk_counts(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
